// File: rtl/dac_atten_pkg.sv
// Shared types and helpers for the AD7528 attenuation-factor sequencer.
package dac_atten_pkg;

  typedef enum logic [1:0] {
    CH_LEFT_A  = 2'd0,
    CH_LEFT_B  = 2'd1,
    CH_RIGHT_A = 2'd2,
    CH_RIGHT_B = 2'd3
  } ch_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } state_e;

  function automatic logic is_a_side(input ch_e idx);
    return (idx == CH_LEFT_A) || (idx == CH_RIGHT_A);
  endfunction

  function automatic logic is_right(input ch_e idx);
    return (idx == CH_RIGHT_A) || (idx == CH_RIGHT_B);
  endfunction

endpackage

// File: rtl/dac_attenuation_sequencer_shifter.sv
// Serialises one captured factor byte MSB first, then strobes the selected DAC.
module dac_serial_shifter
  import dac_atten_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_val,
  input  logic       sel_a,
  input  logic       right,
  output logic       done,
  output logic       datadac,
  output logic       clkdac,
  output logic       csdac1n,
  output logic       csdac2n
);

  localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  state_e        state;
  logic [PW-1:0] phase;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          sel_a_q;
  logic          right_q;

  // Last cycle of GAP, so the owner can drop busy in the IDLE cycle that follows.
  assign done = (state == ST_GAP) && (phase == PH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= '0;
      bitn    <= 3'd7;
      shreg   <= '0;
      sel_a_q <= 1'b0;
      right_q <= 1'b0;
      datadac <= 1'b0;
      clkdac  <= 1'b0;
      csdac1n <= 1'b1;
      csdac2n <= 1'b1;
    end else if (state == ST_IDLE) begin
      if (start) begin
        shreg   <= byte_val;
        sel_a_q <= sel_a;
        right_q <= right;
        bitn    <= 3'd7;
        phase   <= '0;
        state   <= ST_SHIFT_LO;
        clkdac  <= 1'b0;
        datadac <= byte_val[7];
      end
    end else if (phase != PH_LAST) begin
      phase <= phase + 1'b1;
    end else begin
      phase <= '0;
      case (state)
        ST_SHIFT_LO: begin
          clkdac <= 1'b1;
          state  <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          clkdac <= 1'b0;
          if (bitn == 3'd0) begin
            datadac <= sel_a_q;
            state   <= ST_SETUP;
          end else begin
            bitn    <= bitn - 3'd1;
            datadac <= shreg[bitn - 3'd1];
            state   <= ST_SHIFT_LO;
          end
        end
        ST_SETUP: begin
          csdac1n <= right_q;
          csdac2n <= ~right_q;
          state   <= ST_STROBE;
        end
        ST_STROBE: begin
          csdac1n <= 1'b1;
          csdac2n <= 1'b1;
          datadac <= 1'b0;
          state   <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_attenuation_sequencer.sv
// Shadow registers, dirty flags and round-robin arbiter feeding the DAC shifter.
module dac_attenuation_sequencer
  import dac_atten_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter logic [7:0]  DEFAULT_A   = 8'hFF,
  parameter logic [7:0]  DEFAULT_B   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       datadac,
  output logic       clkdac,
  output logic       csdac1n,
  output logic       csdac2n,
  output logic       busy,
  output logic [3:0] pending
);

  logic [7:0] shadow [4];
  ch_e        ptr;
  ch_e        sel;
  ch_e        cand;
  logic       found;
  logic       start;
  logic       done;

  always_comb begin
    sel   = CH_LEFT_A;
    cand  = CH_LEFT_A;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ch_e'(ptr + 2'(i));
      if (!found && pending[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign start = ~busy & found;

  // The write is applied after the capture clear so a same-cycle write keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow[CH_LEFT_A]  <= DEFAULT_A;
      shadow[CH_LEFT_B]  <= DEFAULT_B;
      shadow[CH_RIGHT_A] <= DEFAULT_A;
      shadow[CH_RIGHT_B] <= DEFAULT_B;
      pending <= 4'hF;
      ptr     <= CH_RIGHT_B;
      busy    <= 1'b0;
    end else begin
      if (start) begin
        pending[sel] <= 1'b0;
        ptr          <= sel;
        busy         <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (wr_en) begin
        shadow[wr_sel]  <= wr_data;
        pending[wr_sel] <= 1'b1;
      end
    end
  end

  dac_serial_shifter #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .byte_val(shadow[sel]),
    .sel_a   (is_a_side(sel)),
    .right   (is_right(sel)),
    .done    (done),
    .datadac (datadac),
    .clkdac  (clkdac),
    .csdac1n (csdac1n),
    .csdac2n (csdac2n)
  );

endmodule
